// File: rtl/rtc_seq_pkg.sv
// rtc_seq_pkg: shared FSM encoding, default sweep geometry and index width
// for the RTC refresh sequencer.
package rtc_seq_pkg;
    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, RELEASE} state_t;
    localparam logic [7:0] BASE_ADDR_DEF = 8'h21;
    localparam int N_REGS_DEF = 6;
    localparam int IDX_W = 4;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/rtc_seq_watchdog.sv
// rtc_seq_watchdog: counts consecutive unacknowledged bus cycles and flags the
// cycle in which the count reaches TIMEOUT_CYC.
module rtc_seq_watchdog
    import rtc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);
    logic [7:0] cnt_q, cnt_d;
    assign tc = en && (cnt_q == 8'(TIMEOUT_CYC - 1));
    always_comb cnt_d = (en && !tc) ? cnt_q + 8'd1 : 8'd0;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/rtc_refresh_sequencer.sv
// rtc_refresh_sequencer: sweeps N_REGS RTC registers per frame tick and streams them to
// the text generator, interleaving user writes. RTC_SEQ_TIMEOUT_EN enables the ack watchdog.
module rtc_refresh_sequencer
    import rtc_seq_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int N_REGS = N_REGS_DEF
`ifdef RTC_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_DEF
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_done,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic [7:0] disp_dir,
    output logic [7:0] disp_dato,
    output logic       disp_valid,
    output logic       sweep_busy,
    output logic       timeout_err
);
    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic act_q, act_d, pend_q, pend_d, busy_q, busy_d;
    logic dv_q, dv_d, wd_q, wd_d, terr_q, terr_d;
    logic [7:0] dir_q, dir_d, dato_q, dato_d;
    logic to;

`ifdef RTC_SEQ_TIMEOUT_EN
    rtc_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk(clk),
        .rst(rst),
        .en (bus_req && !bus_ack),
        .tc (to)
    );
`else
    assign to = 1'b0;
`endif

    assign bus_req     = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign bus_we      = (state_q == WR_REQ);
    assign bus_addr    = (state_q == RD_REQ) ? BASE_ADDR + 8'(idx_q) :
                         (state_q == WR_REQ) ? wr_addr : 8'h00;
    assign bus_wdata   = (state_q == WR_REQ) ? wr_data : 8'h00;
    assign wr_done     = wd_q;
    assign disp_dir    = dir_q;
    assign disp_dato   = dato_q;
    assign disp_valid  = dv_q;
    assign sweep_busy  = busy_q;
    assign timeout_err = terr_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        pend_d  = pend_q | frame_tick;
        busy_d  = busy_q;
        dir_d   = dir_q;
        dato_d  = dato_q;
        dv_d    = 1'b0;
        wd_d    = 1'b0;
        terr_d  = terr_q;
        case (state_q)
            IDLE:
                if (wr_req && !wd_q) state_d = WR_REQ;
                else if (pend_d) begin
                    state_d = RD_REQ;
                    act_d   = 1'b1;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                end
            RD_REQ:
                if (bus_ack || to) begin
                    state_d = RELEASE;
                    terr_d  = to;
                    dv_d    = bus_ack;
                    dir_d   = bus_ack ? bus_addr : dir_q;
                    dato_d  = bus_ack ? bus_rdata : dato_q;
                    // An aborted read still counts as done so the sweep moves on
                    if (idx_q == IDX_W'(N_REGS - 1)) begin
                        idx_d  = '0;
                        act_d  = 1'b0;
                        busy_d = pend_d;
                    end else idx_d = idx_q + IDX_W'(1);
                end
            WR_REQ:
                if (bus_ack || to) begin
                    state_d = RELEASE;
                    terr_d  = to;
                    wd_d    = 1'b1;
                end
            RELEASE:
                // wd_q masks the write request still held in its wr_done cycle
                if (!bus_ack) begin
                    if (wr_req && !wd_q) state_d = WR_REQ;
                    else if (act_q) state_d = RD_REQ;
                    else if (pend_d) begin
                        state_d = RD_REQ;
                        act_d   = 1'b1;
                        busy_d  = 1'b1;
                        pend_d  = 1'b0;
                    end else state_d = IDLE;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            act_q   <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            dir_q   <= 8'h00;
            dato_q  <= 8'h00;
            dv_q    <= 1'b0;
            wd_q    <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            dir_q   <= dir_d;
            dato_q  <= dato_d;
            dv_q    <= dv_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
        end
endmodule

// File: tb/tb_rtc_refresh_sequencer.sv
// tb_rtc_refresh_sequencer: table-driven scenarios against a 2-cycle-ack RTC responder,
// plus hand-written reset and latency sequences.
module tb_rtc_refresh_sequencer;
    logic clk = 0, rst = 1, frame_tick = 0, wr_req = 0;
    logic [7:0] wr_addr = 0, wr_data = 0;
    logic bus_ack;
    logic [7:0] bus_rdata;
    logic wr_done, bus_req, bus_we, disp_valid, sweep_busy, timeout_err;
    logic [7:0] bus_addr, bus_wdata, disp_dir, disp_dato;
    logic mute_en = 0;
    logic [7:0] mute_addr = 0;
    int rsp_cnt;
    int checks = 0, errors = 0;

    typedef struct {
        string name;
        bit tick;
        bit wr_now;
        logic [7:0] wr_trig;
        logic [7:0] wa;
        logic [7:0] wdat;
        int extra;
        logic [7:0] mute;
        string exp_seq;
        string exp_dv;
        string exp_lb;
        int exp_wd;
        int exp_falls;
        string exp_terr;
        int exp_mcyc;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    rtc_refresh_sequencer dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .disp_dir(disp_dir), .disp_dato(disp_dato),
        .disp_valid(disp_valid), .sweep_busy(sweep_busy), .timeout_err(timeout_err)
    );

    // RTC responder: ack two cycles after req rises, drop one cycle after req falls
    always @(posedge clk or posedge rst)
        if (rst) begin
            bus_ack <= 0; bus_rdata <= 0; rsp_cnt <= 0;
        end else if (bus_req && !bus_ack) begin
            if (rsp_cnt >= 1 && !(mute_en && bus_addr == mute_addr)) begin
                bus_ack <= 1; bus_rdata <= bus_addr - 8'h11;
            end else rsp_cnt <= rsp_cnt + 1;
        end else if (!bus_req) begin
            bus_ack <= 0; rsp_cnt <= 0;
        end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_s(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {26'd0, wr_done, bus_req, bus_we, bus_addr, bus_wdata, disp_dir, disp_dato,
                disp_valid, sweep_busy, timeout_err};
    endfunction

    task automatic run(input vec_t v);
        string seq = "", dvs = "", lb = "", tl = "";
        int wd = 0, falls = 0, ticks = 0, quiet = 0, mcyc = 0, tviol = 0, ndv = 0;
        bit sent, prev_req = 0, prev_busy = 0, exp_dv = 0, exp_drop = 0;
        logic [7:0] held_addr = 0;
        mute_en = (v.mute != 0); mute_addr = v.mute;
        wr_addr = v.wa; wr_data = v.wdat;
        @(negedge clk);
        frame_tick = v.tick; wr_req = v.wr_now; sent = v.wr_now;
        for (int c = 0; c < 1000 && quiet < 8; c++) begin
            @(negedge clk);
            frame_tick = 0;
            if (disp_valid !== exp_dv) tviol++;
            if (exp_drop && bus_req) tviol++;
            if (prev_req && bus_req && bus_addr !== held_addr) tviol++;
            exp_dv = bus_req && bus_ack && !bus_we;
            exp_drop = bus_req && bus_ack;
            if (bus_req && !prev_req) begin
                seq = {seq, bus_we ? $sformatf("w%02h=%02h ", bus_addr, bus_wdata)
                                   : $sformatf("r%02h ", bus_addr)};
                tl = {tl, timeout_err ? "1" : "0"};
            end
            held_addr = bus_addr; prev_req = bus_req;
            if (v.mute != 0 && bus_req && bus_addr == v.mute) mcyc++;
            if (disp_valid) begin
                ndv++;
                dvs = {dvs, $sformatf("%02h:%02h ", disp_dir, disp_dato)};
                if (disp_dir == 8'h26) lb = {lb, sweep_busy ? "1" : "0"};
            end
            if (prev_busy && !sweep_busy) falls++;
            prev_busy = sweep_busy;
            if (wr_done) begin wd++; wr_req = 0; end
            if (!sent && v.wr_trig != 0 && bus_req && !bus_we && bus_addr == v.wr_trig) begin
                wr_req = 1; sent = 1;
            end
            if (ticks < v.extra && ndv >= 1 && ndv < 5) begin frame_tick = 1; ticks++; end
            quiet = (!bus_req && !sweep_busy && !wr_req && !frame_tick) ? quiet + 1 : 0;
        end
        check({v.name, " completes"}, 64'(quiet >= 8), 64'd1);
        check_s({v.name, " bus seq"}, seq, v.exp_seq);
        check_s({v.name, " disp"}, dvs, v.exp_dv);
        check_s({v.name, " busy@last"}, lb, v.exp_lb);
        check({v.name, " wr_done"}, 64'(wd), 64'(v.exp_wd));
        check({v.name, " busy falls"}, 64'(falls), 64'(v.exp_falls));
        check({v.name, " timing"}, 64'(tviol), 64'd0);
        if (v.mute != 0) begin
            check({v.name, " req cycles"}, 64'(mcyc), 64'(v.exp_mcyc));
            check_s({v.name, " terr log"}, tl, v.exp_terr);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global time limit");
        $fatal(1, "time limit");
    end

    initial begin
        string s6 = "r21 r22 r23 r24 r25 r26 ";
        string d6 = "21:10 22:11 23:12 24:13 25:14 26:15 ";
        tv.push_back('{"sweep", 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, s6, d6, "0", 0, 1, "", 0});
        tv.push_back('{"wr mid", 1, 0, 8'h23, 8'h22, 8'h45, 0, 8'h00,
                       "r21 r22 r23 w22=45 r24 r25 r26 ", d6, "0", 1, 1, "", 0});
        tv.push_back('{"3 ticks", 1, 0, 8'h00, 8'h00, 8'h00, 3, 8'h00,
                       {s6, s6}, {d6, d6}, "10", 0, 1, "", 0});
        tv.push_back('{"tick+wr", 1, 1, 8'h00, 8'h30, 8'h5a, 0, 8'h00,
                       {"w30=5a ", s6}, d6, "0", 1, 1, "", 0});
        tv.push_back('{"wr only", 0, 1, 8'h00, 8'h3f, 8'hc3, 0, 8'h00,
                       "w3f=c3 ", "", "", 1, 0, "", 0});
`ifdef RTC_SEQ_TIMEOUT_EN
        tv.push_back('{"timeout", 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h23, s6,
                       "21:10 22:11 24:13 25:14 26:15 ", "0", 0, 1, "000100", 255});
`endif
        repeat (3) @(posedge clk);
        #1 check("reset state", all_out(), 64'd0);
        @(negedge clk) rst = 0;
        @(negedge clk) check("idle after reset", all_out(), 64'd0);

        frame_tick = 1;
        @(posedge clk);
        #1 check("latency req", 64'(bus_req), 64'd1);
        check("latency addr", 64'(bus_addr), 64'h21);
        check("latency we", 64'(bus_we), 64'd0);
        @(negedge clk) frame_tick = 0;
        #2 rst = 1;
        #1 check("async reset outputs", all_out(), 64'd0);
        @(negedge clk) rst = 0;
        repeat (4) @(negedge clk);
        check("no sweep after reset", {62'd0, bus_req, sweep_busy}, 64'd0);

        foreach (tv[i]) run(tv[i]);
        check("disp hold", {48'd0, disp_dir, disp_dato}, 64'h2615);
        check("timeout_err final", 64'(timeout_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
